// File: rtl/uv_dbg_pkg.sv
// Shared definitions for the debug bus initiator: FSM encoding, exception
// codes and the command length width.
package uv_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RSP   = 2'd2,
        ST_STALE = 2'd3
    } dbg_state_e;

    localparam logic [1:0] EXCP_OK  = 2'b00;
    localparam logic [1:0] EXCP_TMO = 2'b11;

    localparam int CMD_LEN_W = 8;

endpackage

// File: rtl/uv_dbg_res_slot.sv
// One-entry result register. A load in the same cycle as a drain keeps the
// slot valid and holds the newly loaded beat.
module uv_dbg_res_slot #(
    parameter int DLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [1:0]      excp_i,
    input  logic [DLEN-1:0] data_i,
    input  logic            last_i,
    input  logic            rdy_i,
    output logic            vld_o,
    output logic [1:0]      excp_o,
    output logic [DLEN-1:0] data_o,
    output logic            last_o
);

    logic            vld_q, vld_d;
    logic [1:0]      excp_q, excp_d;
    logic [DLEN-1:0] data_q, data_d;
    logic            last_q, last_d;

    always_comb begin
        vld_d  = vld_q;
        excp_d = excp_q;
        data_d = data_q;
        last_d = last_q;
        if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
        if (load_i) begin
            vld_d  = 1'b1;
            excp_d = excp_i;
            data_d = data_i;
            last_d = last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            excp_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            excp_q <= excp_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign vld_o  = vld_q;
    assign excp_o = excp_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: rtl/uv_dbg_mst.sv
// Debug bus initiator: turns single/burst commands into one-at-a-time
// dbg_req/dbg_rsp transactions, with auto-increment, abort on error and timeout.
module uv_dbg_mst
    import uv_dbg_pkg::*;
#(
    parameter int ALEN    = 12,
    parameter int DLEN    = 32,
    parameter int MLEN    = DLEN / 8,
    parameter int TMO_CYC = 256,
    parameter int TMO_W   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 cmd_read,
    input  logic [ALEN-1:0]      cmd_addr,
    input  logic [MLEN-1:0]      cmd_mask,
    input  logic [DLEN-1:0]      cmd_data,
    input  logic [CMD_LEN_W-1:0] cmd_len,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [1:0]           res_excp,
    output logic [DLEN-1:0]      res_data,
    output logic                 res_last,
    input  logic                 stale_clr,
    output logic                 dbg_req_vld,
    input  logic                 dbg_req_rdy,
    output logic                 dbg_req_read,
    output logic [ALEN-1:0]      dbg_req_addr,
    output logic [MLEN-1:0]      dbg_req_mask,
    output logic [DLEN-1:0]      dbg_req_data,
    input  logic                 dbg_rsp_vld,
    output logic                 dbg_rsp_rdy,
    input  logic [1:0]           dbg_rsp_excp,
    input  logic [DLEN-1:0]      dbg_rsp_data
);

    localparam logic             TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    dbg_state_e           state_q, state_d;
    logic                 read_q, read_d;
    logic [ALEN-1:0]      addr_q, addr_d;
    logic [MLEN-1:0]      mask_q, mask_d;
    logic [DLEN-1:0]      data_q, data_d;
    logic [CMD_LEN_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;

    logic            slot_free, cmd_fire, rsp_fire, beat_last, tmo_hit;
    logic            res_load, res_load_last;
    logic [1:0]      res_load_excp;
    logic [DLEN-1:0] res_load_data;

    // A draining slot counts as free so a new beat can land in the same cycle.
    assign slot_free = ~res_vld | res_rdy;
    assign cmd_fire  = cmd_vld & cmd_rdy;
    assign rsp_fire  = dbg_rsp_vld & dbg_rsp_rdy;
    assign beat_last = (cnt_q == '0) | (dbg_rsp_excp != EXCP_OK);
    assign tmo_hit   = TMO_EN & (state_q == ST_RSP) & ~dbg_rsp_vld & slot_free
                     & (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cmd_fire) state_d = ST_REQ;
            ST_REQ:   if (dbg_req_rdy) state_d = ST_RSP;
            ST_RSP: begin
                if (rsp_fire) begin
                    state_d = beat_last ? ST_IDLE : ST_REQ;
                end else if (tmo_hit) begin
                    state_d = ST_STALE;
                end
            end
            ST_STALE: if (rsp_fire || stale_clr) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy     = 1'b0;
        dbg_req_vld = 1'b0;
        dbg_rsp_rdy = 1'b0;
        unique case (state_q)
            ST_IDLE:  cmd_rdy     = ~res_vld;
            ST_REQ:   dbg_req_vld = 1'b1;
            ST_RSP:   dbg_rsp_rdy = slot_free;
            ST_STALE: dbg_rsp_rdy = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        read_d = read_q;
        addr_d = addr_q;
        mask_d = mask_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        tmo_d  = tmo_q;
        if (cmd_fire) begin
            read_d = cmd_read;
            addr_d = cmd_addr;
            mask_d = cmd_mask;
            data_d = cmd_data;
            cnt_d  = cmd_len;
        end
        if (state_q == ST_REQ && dbg_req_rdy) begin
            tmo_d = '0;
        end
        if (state_q == ST_RSP) begin
            if (rsp_fire && !beat_last) begin
                addr_d = addr_q + ALEN'(MLEN);
                cnt_d  = cnt_q - CMD_LEN_W'(1);
            end
            if (TMO_EN && !dbg_rsp_vld && slot_free) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q <= 1'b0;
            addr_q <= '0;
            mask_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
        end else begin
            read_q <= read_d;
            addr_q <= addr_d;
            mask_q <= mask_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign dbg_req_read = read_q;
    assign dbg_req_addr = addr_q;
    assign dbg_req_mask = mask_q;
    assign dbg_req_data = data_q;

    // Responses accepted in STALE are the late answer to a timed-out beat: dropped.
    assign res_load      = (state_q == ST_RSP) & (rsp_fire | tmo_hit);
    assign res_load_excp = tmo_hit ? EXCP_TMO : dbg_rsp_excp;
    assign res_load_data = tmo_hit ? '0 : dbg_rsp_data;
    assign res_load_last = tmo_hit | beat_last;

    uv_dbg_res_slot #(
        .DLEN (DLEN)
    ) u_res_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (res_load),
        .excp_i (res_load_excp),
        .data_i (res_load_data),
        .last_i (res_load_last),
        .rdy_i  (res_rdy),
        .vld_o  (res_vld),
        .excp_o (res_excp),
        .data_o (res_data),
        .last_o (res_last)
    );

endmodule
